// File: rtl/video_fifo_wr_burst_ctrl.sv
// video_fifo_wr_burst_ctrl: drains the video FIFO into DDR as AXI4 write bursts (FIFO pop side in, AXI AW/W/B out, rotating frame buffers, frame_done/overrun/busy status)
module video_fifo_wr_burst_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 28,
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned WL_WIDTH     = 9,
  parameter int unsigned BURST_LEN    = 16,
  parameter int unsigned FRAME_BEATS  = 259200,
  parameter int unsigned FRAME_BASE   = 0,
  parameter int unsigned FRAME_STRIDE = 32'h0080_0000,
  parameter int unsigned NUM_BUF      = 3
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  frame_start,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic [WL_WIDTH-1:0]   fifo_rd_water_level,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [DATA_WIDTH-1:0] axi_wdata,
  output logic                  axi_wlast,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic [1:0]            buf_idx,
  output logic                  frame_done,
  output logic                  frame_overrun,
  output logic                  busy
);
  localparam int unsigned CW  = $clog2(FRAME_BEATS + 1);
  localparam int unsigned BPB = DATA_WIDTH / 8;
  typedef enum logic [2:0] {IDLE, ARMED, AW, WDATA, WRESP} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] remaining_q, fetched_q, sent_q, len;
  logic [ADDR_WIDTH-1:0] addr_q, awaddr_q;
  logic [7:0] awlen_q;
  logic [1:0] buf_idx_q, cnt_q;
  logic busy_q, overrun_q, pend_q, head_q;
  logic [DATA_WIDTH-1:0] sk_q [2];
  logic w_hs, last_beat, last_burst;
  logic [2:0] inflight;
  always_ff @(posedge rd_clk) begin
    if (rd_rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = frame_start ? ARMED : IDLE;
      ARMED:   state_d = (32'(fifo_rd_water_level) >= 32'(len)) ? AW : ARMED;
      AW:      state_d = axi_awready ? WDATA : AW;
      WDATA:   state_d = (w_hs && last_beat) ? WRESP : WDATA;
      WRESP:   state_d = axi_bvalid ? (last_burst ? IDLE : ARMED) : WRESP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    len = (32'(remaining_q) > BURST_LEN) ? CW'(BURST_LEN) : remaining_q;
    last_beat = sent_q == len - CW'(1);
    last_burst = remaining_q == len;
    axi_awvalid = state_q == AW;
    axi_awaddr = awaddr_q;
    axi_awlen = awlen_q;
    axi_wvalid = state_q == WDATA && cnt_q != 2'd0;
    axi_wdata = sk_q[head_q];
    axi_wlast = axi_wvalid && last_beat;
    w_hs = axi_wvalid && axi_wready;
    // count the beat leaving this cycle as already gone so a steady 1 beat/cycle stream keeps fetching
    inflight = {1'b0, cnt_q} + {2'b0, pend_q} - {2'b0, w_hs};
    fifo_rd_en = state_q == WDATA && fetched_q < len && inflight < 3'd2 && !fifo_rd_empty;
    axi_bready = state_q == WRESP;
    frame_done = state_q == WRESP && axi_bvalid && last_burst;
    buf_idx = buf_idx_q;
    frame_overrun = overrun_q;
    busy = busy_q;
  end
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      remaining_q <= '0;
      fetched_q <= '0;
      sent_q <= '0;
      addr_q <= '0;
      awaddr_q <= '0;
      awlen_q <= '0;
      buf_idx_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      overrun_q <= 1'b0;
      pend_q <= 1'b0;
      head_q <= 1'b0;
      sk_q[0] <= '0;
      sk_q[1] <= '0;
    end else begin
      if (state_q == IDLE && frame_start) begin
        remaining_q <= CW'(FRAME_BEATS);
        addr_q <= ADDR_WIDTH'(FRAME_BASE + 32'(buf_idx_q) * FRAME_STRIDE);
        busy_q <= 1'b1;
      end
      if (state_q != IDLE && frame_start) overrun_q <= 1'b1;
      if (state_q == ARMED && state_d == AW) begin
        awaddr_q <= addr_q;
        awlen_q <= 8'(len - CW'(1));
        fetched_q <= '0;
        sent_q <= '0;
      end
      if (fifo_rd_en) fetched_q <= fetched_q + CW'(1);
      if (w_hs) begin
        sent_q <= sent_q + CW'(1);
        head_q <= ~head_q;
      end
      pend_q <= fifo_rd_en;
      // FIFO data lands one cycle after the pop, in the slot just past the current occupants
      if (pend_q) sk_q[head_q ^ cnt_q[0]] <= fifo_rd_data;
      cnt_q <= cnt_q + {1'b0, pend_q} - {1'b0, w_hs};
      if (state_q == WRESP && axi_bvalid) begin
        addr_q <= addr_q + ADDR_WIDTH'(32'(len) * BPB);
        remaining_q <= remaining_q - len;
        if (last_burst) begin
          buf_idx_q <= (32'(buf_idx_q) == NUM_BUF - 1) ? 2'd0 : buf_idx_q + 2'd1;
          busy_q <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_video_fifo_wr_burst_ctrl.sv
// tb_video_fifo_wr_burst_ctrl: randomized self-checking bench for video_fifo_wr_burst_ctrl against a burst-plan reference model
module tb_video_fifo_wr_burst_ctrl;
  localparam int BL = 16;
  localparam int FB = 40;
  localparam int STRIDE = 32'h800;
  localparam int NB = 3;
  logic clk, rd_rst, frame_start, fifo_rd_en, fifo_rd_empty;
  logic [255:0] fifo_rd_data, axi_wdata;
  logic [8:0] fifo_rd_water_level;
  logic [27:0] axi_awaddr;
  logic [7:0] axi_awlen;
  logic axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic [1:0] buf_idx;
  logic frame_done, frame_overrun, busy;
  int checks = 0, failures = 0;
  logic [255:0] fq[$], exp_d[$], wd_q[$];
  logic [27:0] awa_q[$];
  logic [7:0] awl_q[$];
  bit wl_q[$];
  int wc_q[$];
  bit fs_req = 0, rst_req = 0, rnd_mode = 0, pop_pend = 0, bpend = 0;
  bit hold_v = 0, haw_v = 0;
  logic [255:0] hold_d;
  logic [27:0] haw_a;
  logic [7:0] haw_l;
  int pops = 0, done_cnt = 0, hold_err = 0, empty_err = 0, cyc_n = 0;
  video_fifo_wr_burst_ctrl #(
    .BURST_LEN(BL), .FRAME_BEATS(FB), .FRAME_STRIDE(STRIDE), .NUM_BUF(NB)
  ) dut (
    .rd_clk(clk), .rd_rst(rd_rst), .frame_start(frame_start),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_water_level(fifo_rd_water_level),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .buf_idx(buf_idx), .frame_done(frame_done), .frame_overrun(frame_overrun), .busy(busy)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction
  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    if (pop_pend && fq.size() > 0) begin
      fifo_rd_data = fq.pop_front();
      pops++;
    end
    fifo_rd_water_level = 9'(fq.size());
    fifo_rd_empty = fq.size() == 0;
    frame_start = fs_req;
    fs_req = 0;
    rd_rst = rst_req;
    rst_req = 0;
    axi_wready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    axi_awready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    axi_bvalid = bpend;
    #1;
    pop_pend = fifo_rd_en && !rd_rst;
    if (fifo_rd_en && fifo_rd_empty) empty_err++;
    if (hold_v && !(axi_wvalid && axi_wdata === hold_d)) hold_err++;
    if (haw_v && !(axi_awvalid && axi_awaddr === haw_a && axi_awlen === haw_l)) hold_err++;
    hold_v = axi_wvalid && !axi_wready && !rd_rst;
    hold_d = axi_wdata;
    haw_v = axi_awvalid && !axi_awready && !rd_rst;
    haw_a = axi_awaddr;
    haw_l = axi_awlen;
    if (axi_awvalid && axi_awready) begin
      awa_q.push_back(axi_awaddr);
      awl_q.push_back(axi_awlen);
    end
    if (axi_wvalid && axi_wready) begin
      wd_q.push_back(axi_wdata);
      wl_q.push_back(axi_wlast);
      wc_q.push_back(cyc_n);
      if (axi_wlast) bpend = 1;
    end
    if ((axi_bvalid && axi_bready) || rd_rst) bpend = 0;
    if (frame_done) done_cnt++;
  endtask
  task automatic push_words(input int n);
    logic [255:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd256();
      fq.push_back(d);
      exp_d.push_back(d);
    end
  endtask
  task automatic start_frame();
    awa_q.delete(); awl_q.delete(); wd_q.delete(); wl_q.delete(); wc_q.delete(); exp_d.delete();
    pops = 0; done_cnt = 0; hold_err = 0; empty_err = 0;
    fs_req = 1;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_awvalid"}, axi_awvalid, 0);
    chk({tag, "_wvalid"}, axi_wvalid, 0);
    chk({tag, "_rd_en"}, fifo_rd_en, 0);
    chk({tag, "_bready"}, axi_bready, 0);
    chk({tag, "_wlast"}, axi_wlast, 0);
    chk({tag, "_awaddr"}, axi_awaddr, 0);
    chk({tag, "_awlen"}, axi_awlen, 0);
    chk({tag, "_wdata_nz"}, |axi_wdata, 0);
    chk({tag, "_buf_idx"}, buf_idx, 0);
    chk({tag, "_overrun"}, frame_overrun, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask
  task automatic finish_frame(input int b, input bit ovr, input bit rate);
    int n = 0, bad = 0, badl = 0, rem, len;
    bit fired = 0, el;
    while (done_cnt == 0 && n < 3000) begin
      if (ovr && !fired && wd_q.size() >= 5) begin
        fs_req = 1;
        fired = 1;
      end
      cyc();
      n++;
    end
    repeat (3) cyc();
    chk($sformatf("f%0d_done_count", b), done_cnt, 1);
    chk($sformatf("f%0d_busy_after", b), busy, 0);
    chk($sformatf("f%0d_buf_idx_after", b), buf_idx, (b + 1) % NB);
    chk($sformatf("f%0d_aw_count", b), awa_q.size(), (FB + BL - 1) / BL);
    for (int i = 0; i < awa_q.size(); i++) begin
      rem = FB - BL * i;
      len = rem < BL ? rem : BL;
      chk($sformatf("f%0d_awaddr%0d", b, i), awa_q[i], b * STRIDE + i * BL * 32);
      chk($sformatf("f%0d_awlen%0d", b, i), awl_q[i], len - 1);
    end
    chk($sformatf("f%0d_beat_count", b), wd_q.size(), FB);
    for (int j = 0; j < wd_q.size() && j < exp_d.size(); j++) begin
      el = ((j + 1) % BL == 0) || (j + 1 == FB);
      if (wd_q[j] !== exp_d[j]) bad++;
      if (wl_q[j] !== el) badl++;
    end
    chk($sformatf("f%0d_wdata_order", b), bad, 0);
    chk($sformatf("f%0d_wlast_pos", b), badl, 0);
    chk($sformatf("f%0d_pops", b), pops, FB);
    chk($sformatf("f%0d_valid_hold", b), hold_err, 0);
    chk($sformatf("f%0d_pop_when_empty", b), empty_err, 0);
    if (rate && wc_q.size() >= BL) chk("burst0_rate", wc_q[BL-1] - wc_q[0], BL - 1);
  endtask
  initial begin
    int n;
    rd_rst = 1; frame_start = 0; fifo_rd_data = '0; fifo_rd_empty = 1; fifo_rd_water_level = '0;
    axi_awready = 1; axi_wready = 1; axi_bvalid = 0;
    repeat (3) begin
      rst_req = 1;
      cyc();
    end
    cyc();
    chk_idle("reset");
    start_frame();
    push_words(BL - 1);
    repeat (10) cyc();
    chk("gate_awvalid_lvl15", axi_awvalid, 0);
    chk("gate_aw_seen_lvl15", awa_q.size(), 0);
    chk("gate_busy", busy, 1);
    push_words(1);
    cyc();
    cyc();
    chk("gate_awvalid_lvl16", axi_awvalid, 1);
    chk("gate_awaddr_lvl16", axi_awaddr, 0);
    push_words(FB - BL);
    finish_frame(0, 0, 1);
    rnd_mode = 1;
    start_frame(); push_words(FB); finish_frame(1, 0, 0);
    start_frame(); push_words(FB); finish_frame(2, 1, 0);
    chk("overrun_set", frame_overrun, 1);
    start_frame(); push_words(FB); finish_frame(0, 0, 0);
    chk("overrun_sticky", frame_overrun, 1);
    start_frame(); push_words(FB);
    n = 0;
    while (wd_q.size() < 4 && n < 500) begin
      cyc();
      n++;
    end
    chk("rst_reached_beat5", wd_q.size() >= 4, 1);
    rst_req = 1;
    cyc();
    cyc();
    chk_idle("rst_mid");
    fq.delete();
    pop_pend = 0;
    cyc();
    start_frame(); push_words(FB); finish_frame(0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
